// File: rtl/chacha_stream.sv
// -----------------------------------------------------------------------------
// chacha_stream
//
// ChaCha keystream generator.  Key, nonce and block counter are loaded a byte
// at a time while the block is idle.  A block is computed one quarter-round
// per clock cycle and then streamed out as 64 bytes.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid, in_first  byte strobe; in_first rewinds the field byte pointer
//   in_sel, in_data     field select (0 key, 1 nonce, 2 counter, 3 ignored)
//   in_ready            loading allowed (IDLE only)
//   start               one-cycle request to compute a block (IDLE only)
//   hold                freezes quarter-round progress in CALC
//   busy                high while the block is being computed
//   out_valid/out_ready keystream byte handshake
//   out_data, out_last  keystream byte, high with byte 63 of a block
//   ctr_wrap            sticky flag: block counter wrapped from all-ones to 0
//   dbg_state           current FSM state (0 IDLE, 1 CALC, 2 OUT)
//
// Handshake: an input byte is taken on a clock edge where in_valid and
// in_ready are both high; a keystream byte is taken on a clock edge where
// out_valid and out_ready are both high.  out_data holds while out_ready is low.
//
// Parameters
//   ROUNDS  8, 12 or 20
//   CTR_W   32: 32-bit counter in word 12, 96-bit nonce in words 13..15
//           64: 64-bit counter in words 12..13, 64-bit nonce in words 14..15
//   AUTO    1: next block starts by itself after byte 63 is read
// -----------------------------------------------------------------------------
module chacha_stream #(
   parameter int ROUNDS = 20,
   parameter int CTR_W  = 32,
   parameter int AUTO   = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic       in_first,
   input  logic [1:0] in_sel,
   input  logic [7:0] in_data,
   output logic       in_ready,
   input  logic       start,
   input  logic       hold,
   output logic       busy,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_last,
   output logic       ctr_wrap,
   output logic [1:0] dbg_state
);

   localparam int NQR         = 4 * ROUNDS;
   localparam int QW          = $clog2(NQR);
   localparam int CTR_BYTES   = CTR_W / 8;
   localparam int NONCE_BYTES = 16 - CTR_BYTES;

   // Field positions as byte addresses into the 64-byte state.
   localparam logic [5:0] KEY_BASE   = 6'd16;
   localparam logic [5:0] CTR_BASE   = 6'd48;
   localparam logic [5:0] NONCE_BASE = 6'(48 + CTR_BYTES);
   localparam logic [5:0] KEY_LEN    = 6'd32;
   localparam logic [5:0] CTR_LEN    = 6'(CTR_BYTES);
   localparam logic [5:0] NONCE_LEN  = 6'(NONCE_BYTES);

   localparam logic [QW-1:0] QR_LAST = QW'(NQR - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Loaded input state: words 4..11 and 12..15 (counter + nonce).
   logic [31:0] key_w  [8];
   logic [31:0] tail_w [4];
   logic [5:0]  ptr    [4];     // per-field byte pointer; entry 3 unused
   logic        wrap_q;

   // Working state and sequencing.
   logic [31:0] work [16];
   logic [QW-1:0] qr_cnt;
   logic [5:0]  k;

   // ---------------------------------------------------------------------------
   // Full 16-word input state view
   // ---------------------------------------------------------------------------
   logic [31:0] in_st [16];
   logic [31:0] ld_st [16];

   always_comb begin
      in_st[0] = 32'h61707865;
      in_st[1] = 32'h3320646e;
      in_st[2] = 32'h79622d32;
      in_st[3] = 32'h6b206574;
      for (int i = 0; i < 8; i++) in_st[4 + i] = key_w[i];
      for (int i = 0; i < 4; i++) in_st[12 + i] = tail_w[i];
   end

   // Counter increment; upper words pass through untouched for CTR_W=32.
   logic [63:0]      ctr_wide;
   logic [63:0]      ctr_inc_w;
   logic [CTR_W-1:0] ctr_cur;
   logic             ctr_all1;

   always_comb begin
      ctr_wide  = {tail_w[1], tail_w[0]};
      ctr_cur   = ctr_wide[CTR_W-1:0];
      ctr_all1  = &ctr_cur;
      ctr_inc_w = ctr_wide;
      ctr_inc_w[CTR_W-1:0] = ctr_cur + CTR_W'(1);
   end

   // A block launched straight out of OUT must already see the incremented
   // counter, since the counter register updates on that same edge.
   always_comb begin
      for (int i = 0; i < 16; i++) ld_st[i] = in_st[i];
      if (state == S_OUT) begin
         ld_st[12] = ctr_inc_w[31:0];
         ld_st[13] = ctr_inc_w[63:32];
      end
   end

   // ---------------------------------------------------------------------------
   // Handshakes
   // ---------------------------------------------------------------------------
   logic out_hs;
   logic last_hs;

   assign in_ready  = (state == S_IDLE);
   assign busy      = (state == S_CALC);
   assign out_valid = (state == S_OUT);
   assign out_last  = (state == S_OUT) && (k == 6'd63);
   assign ctr_wrap  = wrap_q;
   assign dbg_state = state;

   assign out_hs  = (state == S_OUT) && out_ready;
   assign last_hs = out_hs && (k == 6'd63);

   // ---------------------------------------------------------------------------
   // Field write decode
   // ---------------------------------------------------------------------------
   logic       wr_beat;
   logic       wr_ok;
   logic [5:0] f_base;
   logic [5:0] f_len;
   logic [5:0] cur_ptr;
   logic [5:0] wr_addr;
   logic [3:0] wr_word;
   logic [2:0] key_idx;
   logic [4:0] wr_lane;

   always_comb begin
      wr_beat = in_valid && in_ready && (in_sel != 2'd3);
      f_base  = KEY_BASE;
      f_len   = KEY_LEN;
      case (in_sel)
         2'd1: begin
            f_base = NONCE_BASE;
            f_len  = NONCE_LEN;
         end
         2'd2: begin
            f_base = CTR_BASE;
            f_len  = CTR_LEN;
         end
         default: ;
      endcase
      cur_ptr = in_first ? 6'd0 : ptr[in_sel];
      wr_ok   = wr_beat && (cur_ptr < f_len);
      wr_addr = f_base + cur_ptr;
      wr_word = wr_addr[5:2];
      key_idx = 3'(wr_word - 4'd4);
      wr_lane = {wr_addr[1:0], 3'b000};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) key_w[i] <= '0;
         for (int i = 0; i < 4; i++) tail_w[i] <= '0;
         for (int i = 0; i < 4; i++) ptr[i] <= '0;
         wrap_q <= 1'b0;
      end else begin
         // Pointer stops at the field length so later bytes stay dropped.
         if (wr_beat) ptr[in_sel] <= wr_ok ? cur_ptr + 6'd1 : cur_ptr;

         if (wr_ok) begin
            if (wr_word[3:2] == 2'b11) tail_w[wr_word[1:0]][wr_lane +: 8] <= in_data;
            else                       key_w[key_idx][wr_lane +: 8] <= in_data;
         end

         // Writes happen only in IDLE and increments only in OUT, so the
         // two never collide.
         if (last_hs) begin
            tail_w[0] <= ctr_inc_w[31:0];
            tail_w[1] <= ctr_inc_w[63:32];
         end

         if (wr_ok && (in_sel == 2'd2)) wrap_q <= 1'b0;
         else if (last_hs && ctr_all1)  wrap_q <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Quarter-round select and datapath
   // ---------------------------------------------------------------------------
   // Within a double round qr_cnt[2] picks column (0) or diagonal (1) pass and
   // qr_cnt[1:0] picks the lane j.  Diagonals rotate rows 1..3 by 1..3 lanes.
   logic [1:0]  qj, qb, qc, qd;
   logic        diag;
   logic [3:0]  ia, ib, ic, id;
   logic [31:0] a1, b1, c1, d1, a2, b2, c2, d2;

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   always_comb begin
      qj   = qr_cnt[1:0];
      diag = qr_cnt[2];
      qb   = qj + {1'b0, diag};
      qc   = qj + {diag, 1'b0};
      qd   = qj + {diag, diag};
      ia   = {2'b00, qj};
      ib   = {2'b01, qb};
      ic   = {2'b10, qc};
      id   = {2'b11, qd};

      a1 = work[ia] + work[ib];
      d1 = rotl(work[id] ^ a1, 16);
      c1 = work[ic] + d1;
      b1 = rotl(work[ib] ^ c1, 12);
      a2 = a1 + b1;
      d2 = rotl(d1 ^ a2, 8);
      c2 = c1 + d2;
      b2 = rotl(b1 ^ c2, 7);
   end

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   logic load_work;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_work = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_CALC;
               load_work = 1'b1;
            end
         end
         S_CALC: begin
            if (!hold && (qr_cnt == QR_LAST)) state_nxt = S_OUT;
         end
         S_OUT: begin
            if (last_hs) begin
               if (AUTO != 0) begin
                  state_nxt = S_CALC;
                  load_work = 1'b1;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) work[i] <= '0;
         qr_cnt <= '0;
         k      <= '0;
      end else begin
         if (load_work) begin
            for (int i = 0; i < 16; i++) work[i] <= ld_st[i];
            qr_cnt <= '0;
         end else if ((state == S_CALC) && !hold) begin
            work[ia] <= a2;
            work[ib] <= b2;
            work[ic] <= c2;
            work[id] <= d2;
            qr_cnt   <= qr_cnt + QW'(1);
         end
         // k wraps 63 -> 0 on the last handshake, ready for the next block.
         if (out_hs) k <= k + 6'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Keystream output: working word plus input word, little-endian bytes
   // ---------------------------------------------------------------------------
   logic [31:0] sum_w;

   always_comb begin
      sum_w    = work[k[5:2]] + in_st[k[5:2]];
      out_data = (state == S_OUT) ? sum_w[{k[1:0], 3'b000} +: 8] : 8'd0;
   end

endmodule

// File: tb/tb_chacha_stream.sv
// -----------------------------------------------------------------------------
// tb_chacha_stream
//
// Directed bench for chacha_stream.  Two instances share all inputs:
//   dut    ROUNDS=20, CTR_W=32, AUTO=1
//   dut_b  ROUNDS=20, CTR_W=64, AUTO=0
// Expected keystream comes from a reference block function in this file and
// from hand-copied leading bytes of known ChaCha20 vectors.
// -----------------------------------------------------------------------------
module tb_chacha_stream;

   localparam int ROUNDS = 20;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       in_valid = 1'b0;
   logic       in_first = 1'b0;
   logic [1:0] in_sel = 2'd0;
   logic [7:0] in_data = 8'd0;
   logic       start = 1'b0;
   logic       hold = 1'b0;
   logic       out_ready = 1'b0;

   logic       in_ready, busy, out_valid, out_last, ctr_wrap;
   logic [7:0] out_data;
   logic [1:0] dbg_state;
   logic       in_ready_b, busy_b, out_valid_b, out_last_b, ctr_wrap_b;
   logic [7:0] out_data_b;
   logic [1:0] dbg_state_b;

   chacha_stream #(.ROUNDS(ROUNDS), .CTR_W(32), .AUTO(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_first(in_first), .in_sel(in_sel), .in_data(in_data),
      .in_ready(in_ready), .start(start), .hold(hold), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .ctr_wrap(ctr_wrap), .dbg_state(dbg_state)
   );

   chacha_stream #(.ROUNDS(ROUNDS), .CTR_W(64), .AUTO(0)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_first(in_first), .in_sel(in_sel), .in_data(in_data),
      .in_ready(in_ready_b), .start(start), .hold(hold), .busy(busy_b),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
      .out_last(out_last_b), .ctr_wrap(ctr_wrap_b), .dbg_state(dbg_state_b)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- scoreboard
   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_b_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------------- reference
   function automatic logic [31:0] rl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [511:0] ref_block(input logic [511:0] s);
      logic [31:0] x [16];
      logic [511:0] ks;
      for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
      for (int r = 0; r < ROUNDS / 2; r++) begin
         for (int h = 0; h < 2; h++) begin
            for (int j = 0; j < 4; j++) begin
               int a, b, c, d;
               a = j;
               b = 4 + ((j + h) % 4);
               c = 8 + ((j + 2 * h) % 4);
               d = 12 + ((j + 3 * h) % 4);
               x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 16);
               x[c] = x[c] + x[d]; x[b] = rl(x[b] ^ x[c], 12);
               x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 8);
               x[c] = x[c] + x[d]; x[b] = rl(x[b] ^ x[c], 7);
            end
         end
      end
      for (int i = 0; i < 16; i++) ks[32*i +: 32] = x[i] + s[32*i +: 32];
      return ks;
   endfunction

   function automatic logic [511:0] make_state(input logic [255:0] key, input logic [63:0] ctr,
                                                input logic [95:0] nonce, input bit is64);
      logic [511:0] s;
      s[127:0]   = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
      s[383:128] = key;
      if (is64) s[511:384] = {nonce[63:0], ctr};
      else      s[511:384] = {nonce, ctr[31:0]};
      return s;
   endfunction

   task automatic push_exp(input logic [511:0] ks, input bit to_b);
      for (int i = 0; i < 64; i++) begin
         if (to_b) exp_b_q.push_back(ks[8*i +: 8]);
         else      exp_q.push_back(ks[8*i +: 8]);
      end
   endtask

   // ---------------------------------------------------------------- drivers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic write_byte(input logic [1:0] sel, input logic first, input logic [7:0] data);
      in_valid = 1'b1;
      in_sel   = sel;
      in_first = first;
      in_data  = data;
      tick();
      in_valid = 1'b0;
      in_first = 1'b0;
   endtask

   task automatic write_field(input logic [1:0] sel, input logic [255:0] val, input int len);
      for (int i = 0; i < len; i++) write_byte(sel, (i == 0), val[8*i +: 8]);
   endtask

   // Counts cycles from the edge that launched the block (n = 1) until
   // out_valid; hold is raised for cycles hold_from .. hold_from+hold_len-1.
   task automatic wait_valid(input int hold_from, input int hold_len, output int n);
      n = 1;
      while (!out_valid && n < 400) begin
         hold = (n >= hold_from) && (n < hold_from + hold_len);
         tick();
         n++;
      end
      hold = 1'b0;
   endtask

   task automatic start_block(input int hold_from, input int hold_len, output int n);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start", busy, 1'b1);
      wait_valid(hold_from, hold_len, n);
   endtask

   // Drains one block, checking every byte against the expected queue(s),
   // the first eight bytes against a hand-copied anchor, and out_last.
   task automatic read_block(input string tag, input bit rnd_ready, input bit chk_b,
                             input bit use_anchor, input logic [63:0] anchor,
                             input bit disturb);
      int n = 0;
      int budget = 0;
      bit done_dist = 1'b0;
      logic [7:0] e;
      while (n < 64 && budget < 2000) begin
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (disturb && !done_dist && n == 20) begin
            start    = 1'b1;
            in_valid = 1'b1;
            in_sel   = 2'd0;
            in_first = 1'b1;
            in_data  = 8'hff;
            done_dist = 1'b1;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check({tag, "_underflow"}, 1, 0);
            else begin
               e = exp_q.pop_front();
               check($sformatf("%s_byte%0d", tag, n), out_data, e);
            end
            if (use_anchor && n < 8) check($sformatf("%s_anchor%0d", tag, n), out_data, anchor[8*n +: 8]);
            if (n == 62) check({tag, "_last62"}, out_last, 1'b0);
            if (n == 63) check({tag, "_last63"}, out_last, 1'b1);
            if (chk_b) begin
               if (exp_b_q.size() == 0) check({tag, "_b_underflow"}, 1, 0);
               else begin
                  e = exp_b_q.pop_front();
                  check($sformatf("%s_b_byte%0d", tag, n), out_data_b, e);
               end
            end
            n++;
         end
         tick();
         start    = 1'b0;
         in_valid = 1'b0;
         in_first = 1'b0;
         budget++;
      end
      out_ready = 1'b0;
      if (n < 64) check({tag, "_timeout"}, n, 64);
   endtask

   // ---------------------------------------------------------------- stimulus
   localparam logic [63:0] ANCHOR_RFC   = 64'h15593bd1e4e7f110;
   localparam logic [63:0] ANCHOR_ZERO  = 64'h903df1a0ade0b876;
   localparam logic [63:0] ANCHOR_ZERO1 = 64'h7a385155bee7079f;

   logic [255:0] key_rfc;
   logic [95:0]  nonce_rfc;
   int lat;

   task automatic load_rfc();
      write_field(2'd0, key_rfc, 32);
      write_field(2'd1, {160'd0, nonce_rfc}, 12);
      write_field(2'd2, 256'd1, 4);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) key_rfc[8*i +: 8] = 8'(i);
      nonce_rfc = 96'h00000000_4a000000_09000000;

      // Reset state
      do_reset();
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_ctr_wrap", ctr_wrap, 1'b0);
      check("rst_out_data", out_data, 8'd0);

      // Known-answer block; pointer rewind, over-length and sel=3 drops;
      // start and key write during OUT must not disturb anything.
      write_byte(2'd0, 1'b1, 8'haa);
      write_byte(2'd0, 1'b0, 8'hbb);
      write_byte(2'd0, 1'b0, 8'hcc);
      write_field(2'd0, key_rfc, 32);
      write_byte(2'd0, 1'b0, 8'hee);
      write_byte(2'd3, 1'b1, 8'h55);
      write_field(2'd1, {160'd0, nonce_rfc}, 12);
      write_field(2'd2, 256'd1, 4);
      push_exp(ref_block(make_state(key_rfc, 64'd1, nonce_rfc, 1'b0)), 1'b0);
      start_block(0, 0, lat);
      check("lat_rfc", lat, 81);
      read_block("rfc", 1'b0, 1'b0, 1'b1, ANCHOR_RFC, 1'b1);
      check("auto_busy", busy, 1'b1);
      check("rfc_no_wrap", ctr_wrap, 1'b0);
      push_exp(ref_block(make_state(key_rfc, 64'd2, nonce_rfc, 1'b0)), 1'b0);
      wait_valid(0, 0, lat);
      check("lat_auto", lat, 81);
      read_block("rfc2", 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);

      // All-zero inputs on both counter layouts; AUTO continues, AUTO=0 idles
      do_reset();
      push_exp(ref_block(make_state(256'd0, 64'd0, 96'd0, 1'b0)), 1'b0);
      push_exp(ref_block(make_state(256'd0, 64'd0, 96'd0, 1'b1)), 1'b1);
      start_block(0, 0, lat);
      check("lat_zero", lat, 81);
      read_block("zero", 1'b0, 1'b1, 1'b1, ANCHOR_ZERO, 1'b0);
      check("zero_auto_busy", busy, 1'b1);
      check("zero_b_idle", in_ready_b, 1'b1);
      push_exp(ref_block(make_state(256'd0, 64'd1, 96'd0, 1'b0)), 1'b0);
      wait_valid(0, 0, lat);
      read_block("zero2", 1'b0, 1'b0, 1'b1, ANCHOR_ZERO1, 1'b0);

      // Counter wrap: 32-bit dut takes 4 of the 8 bytes, 64-bit dut_b all 8
      do_reset();
      write_field(2'd2, {192'd0, 64'hffffffff_ffffffff}, 8);
      push_exp(ref_block(make_state(256'd0, 64'hffffffff_ffffffff, 96'd0, 1'b0)), 1'b0);
      push_exp(ref_block(make_state(256'd0, 64'hffffffff_ffffffff, 96'd0, 1'b1)), 1'b1);
      start_block(0, 0, lat);
      read_block("wrap", 1'b0, 1'b1, 1'b0, 64'd0, 1'b0);
      check("wrap_flag", ctr_wrap, 1'b1);
      check("wrap_flag_b", ctr_wrap_b, 1'b1);
      check("wrap_auto_busy", busy, 1'b1);
      write_byte(2'd2, 1'b1, 8'h05);
      check("wrap_clear_b", ctr_wrap_b, 1'b0);
      check("wrap_kept_calc", ctr_wrap, 1'b1);
      push_exp(ref_block(make_state(256'd0, 64'd0, 96'd0, 1'b0)), 1'b0);
      wait_valid(0, 0, lat);
      read_block("wrap_next", 1'b0, 1'b0, 1'b1, ANCHOR_ZERO, 1'b0);
      check("wrap_sticky", ctr_wrap, 1'b1);

      // Hold for 10 CALC cycles, random out_ready
      do_reset();
      load_rfc();
      push_exp(ref_block(make_state(key_rfc, 64'd1, nonce_rfc, 1'b0)), 1'b0);
      start_block(20, 10, lat);
      check("lat_hold", lat, 91);
      read_block("hold", 1'b1, 1'b0, 1'b1, ANCHOR_RFC, 1'b0);

      // Reset in the middle of CALC aborts the block
      do_reset();
      load_rfc();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (39) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_busy", busy, 1'b0);
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_in_ready", in_ready, 1'b1);
      repeat (50) tick();
      check("abort_no_output", out_valid, 1'b0);
      load_rfc();
      push_exp(ref_block(make_state(key_rfc, 64'd1, nonce_rfc, 1'b0)), 1'b0);
      start_block(0, 0, lat);
      check("lat_after_abort", lat, 81);
      read_block("after_abort", 1'b0, 1'b0, 1'b1, ANCHOR_RFC, 1'b0);

      check("exp_q_empty", exp_q.size(), 0);
      check("exp_b_q_empty", exp_b_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
